// File: rtl/axi_lite_slave_router.sv
// axi_lite_slave_router: single-master AXI4-Lite router steering AW/W/B and AR/R to one of NUM_SLAVES slaves, DECERR for out-of-range indices
module axi_lite_slave_router #(
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32,
  parameter int NUM_SLAVES = 5
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [2:0]                   aw_slave,
  input  logic [2:0]                   ar_slave,
  input  logic [ADDR_W-1:0]            s_awaddr,
  input  logic                         s_awvalid,
  output logic                         s_awready,
  input  logic [DATA_W-1:0]            s_wdata,
  input  logic [DATA_W/8-1:0]          s_wstrb,
  input  logic                         s_wvalid,
  output logic                         s_wready,
  output logic [1:0]                   s_bresp,
  output logic                         s_bvalid,
  input  logic                         s_bready,
  input  logic [ADDR_W-1:0]            s_araddr,
  input  logic                         s_arvalid,
  output logic                         s_arready,
  output logic [DATA_W-1:0]            s_rdata,
  output logic [1:0]                   s_rresp,
  output logic                         s_rvalid,
  input  logic                         s_rready,
  output logic [ADDR_W-1:0]            m_awaddr,
  output logic [NUM_SLAVES-1:0]        m_awvalid,
  input  logic [NUM_SLAVES-1:0]        m_awready,
  output logic [DATA_W-1:0]            m_wdata,
  output logic [DATA_W/8-1:0]          m_wstrb,
  output logic [NUM_SLAVES-1:0]        m_wvalid,
  input  logic [NUM_SLAVES-1:0]        m_wready,
  input  logic [2*NUM_SLAVES-1:0]      m_bresp,
  input  logic [NUM_SLAVES-1:0]        m_bvalid,
  output logic [NUM_SLAVES-1:0]        m_bready,
  output logic [ADDR_W-1:0]            m_araddr,
  output logic [NUM_SLAVES-1:0]        m_arvalid,
  input  logic [NUM_SLAVES-1:0]        m_arready,
  input  logic [DATA_W*NUM_SLAVES-1:0] m_rdata,
  input  logic [2*NUM_SLAVES-1:0]      m_rresp,
  input  logic [NUM_SLAVES-1:0]        m_rvalid,
  output logic [NUM_SLAVES-1:0]        m_rready
);
  typedef enum logic [1:0] {W_IDLE, W_FWD, W_RESP, W_ERR} w_state_t;
  typedef enum logic [1:0] {R_IDLE, R_FWD, R_DATA, R_ERR} r_state_t;
  w_state_t ws, ws_n;
  r_state_t rs, rs_n;
  logic [2:0] wsel, rsel;
  logic aw_pend, w_pend, aw_ok, ar_ok, aw_hs, w_hs, w_go;
  assign aw_ok = {1'b0, aw_slave} < 4'(NUM_SLAVES);
  assign ar_ok = {1'b0, ar_slave} < 4'(NUM_SLAVES);
  assign aw_hs = |(m_awvalid & m_awready);
  assign w_hs  = |(m_wvalid & m_wready);
  assign w_go  = ws == W_IDLE && s_awvalid && s_wvalid;
  always_ff @(posedge clk) begin
    if (rst) begin
      ws       <= W_IDLE;
      rs       <= R_IDLE;
      wsel     <= '0;
      rsel     <= '0;
      aw_pend  <= 1'b0;
      w_pend   <= 1'b0;
      m_awaddr <= '0;
      m_wdata  <= '0;
      m_wstrb  <= '0;
      m_araddr <= '0;
    end else begin
      ws <= ws_n;
      rs <= rs_n;
      if (w_go) begin
        wsel     <= aw_slave;
        m_awaddr <= s_awaddr;
        m_wdata  <= s_wdata;
        m_wstrb  <= s_wstrb;
        aw_pend  <= aw_ok;
        w_pend   <= aw_ok;
      end else begin
        aw_pend <= aw_pend && !aw_hs;
        w_pend  <= w_pend && !w_hs;
      end
      if (rs == R_IDLE && s_arvalid) begin
        rsel     <= ar_slave;
        m_araddr <= s_araddr;
      end
    end
  end
  always_comb begin
    ws_n      = ws;
    rs_n      = rs;
    s_awready = ws == W_IDLE && !rst;
    s_wready  = ws == W_IDLE && !rst;
    s_arready = rs == R_IDLE && !rst;
    s_bvalid  = ws == W_ERR;
    s_bresp   = ws == W_ERR ? 2'b11 : 2'b00;
    s_rvalid  = rs == R_ERR;
    s_rresp   = rs == R_ERR ? 2'b11 : 2'b00;
    s_rdata   = '0;
    m_awvalid = '0;
    m_wvalid  = '0;
    m_bready  = '0;
    m_arvalid = '0;
    m_rready  = '0;
    for (int i = 0; i < NUM_SLAVES; i++) begin
      if (ws == W_FWD && wsel == 3'(i)) begin
        m_awvalid[i] = aw_pend;
        m_wvalid[i]  = w_pend;
      end
      if (ws == W_RESP && wsel == 3'(i)) begin
        m_bready[i] = s_bready;
        s_bvalid    = m_bvalid[i];
        s_bresp     = m_bresp[2*i+:2];
      end
      if (rs == R_FWD && rsel == 3'(i)) m_arvalid[i] = 1'b1;
      if (rs == R_DATA && rsel == 3'(i)) begin
        m_rready[i] = s_rready;
        s_rvalid    = m_rvalid[i];
        s_rdata     = m_rdata[DATA_W*i+:DATA_W];
        s_rresp     = m_rresp[2*i+:2];
      end
    end
    case (ws)
      W_IDLE:  if (s_awvalid && s_wvalid) ws_n = aw_ok ? W_FWD : W_ERR;
      W_FWD:   if ((!aw_pend || aw_hs) && (!w_pend || w_hs)) ws_n = W_RESP;
      default: if (s_bvalid && s_bready) ws_n = W_IDLE;
    endcase
    case (rs)
      R_IDLE:  if (s_arvalid) rs_n = ar_ok ? R_FWD : R_ERR;
      R_FWD:   if (|(m_arvalid & m_arready)) rs_n = R_DATA;
      default: if (s_rvalid && s_rready) rs_n = R_IDLE;
    endcase
  end
endmodule
